// File: rtl/binarysearch_datapath_if.sv
// ---------------------------------------------------------------------------
// binarysearch_datapath_if
//
// Purpose: groups the binary-search datapath's control strobes, search key,
// RAM read port and result signals into one bundle.
//
// Signals:
//   A_in      search key, captured on load_A
//   load_A    start a new search (controller strobe)
//   set_L     bound-update strobe (controller)
//   set_R     bound-update strobe (controller)
//   set_M     midpoint strobe (controller)
//   mem_addr  RAM read address (datapath -> RAM)
//   mem_rdata RAM read data, one cycle after mem_addr (RAM -> datapath)
//   F         found, combinational, compare cycle only
//   NF        not found, combinational, compare cycle only
//   Loc       registered address of the match
//   found     registered sticky result flag
//   steps     registered compare-cycle count, saturating at 7
//
// Modports:
//   master  controller / RAM side (drives strobes, key and read data)
//   slave   datapath side (drives address and results)
// ---------------------------------------------------------------------------
interface binarysearch_datapath_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] A_in;
    logic              load_A;
    logic              set_L;
    logic              set_R;
    logic              set_M;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              F;
    logic              NF;
    logic [ADDR_W-1:0] Loc;
    logic              found;
    logic [2:0]        steps;

    modport master (
        output A_in,
        output load_A,
        output set_L,
        output set_R,
        output set_M,
        output mem_rdata,
        input  mem_addr,
        input  F,
        input  NF,
        input  Loc,
        input  found,
        input  steps
    );

    modport slave (
        input  A_in,
        input  load_A,
        input  set_L,
        input  set_R,
        input  set_M,
        input  mem_rdata,
        output mem_addr,
        output F,
        output NF,
        output Loc,
        output found,
        output steps
    );
endinterface

// File: rtl/binarysearch_datapath.sv
// ---------------------------------------------------------------------------
// binarysearch_datapath
//
// Purpose: datapath of a binary search over a sorted, unsigned, synchronous
// RAM with one cycle of read latency. The controller alternates "grab"
// cycles (latch the midpoint, RAM fetches it) with "compare" cycles (the
// fetched word is compared against the key and the bounds narrow).
//
// Ports:
//   clock  rising-edge clock for all state
//   reset  asynchronous, active-low reset
//   bus    binarysearch_datapath_if.slave: strobes, key, RAM port, results
//
// Parameters:
//   ADDR_W  word-address width of the searched memory (depth 2^ADDR_W)
//   DATA_W  width of memory words and of the key
// ---------------------------------------------------------------------------
module binarysearch_datapath #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    binarysearch_datapath_if.slave  bus
);

    localparam logic [ADDR_W-1:0] R_INIT = {ADDR_W{1'b1}};

    // Saturating step counter increment: stops at 7 so an overlong
    // search cannot wrap back to a small count.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    logic [DATA_W-1:0] a_p0;
    logic [ADDR_W-1:0] l_p0;
    logic [ADDR_W-1:0] r_p0;
    logic [ADDR_W-1:0] m_p0;
    logic              found_p0;
    logic [ADDR_W-1:0] loc_p0;
    logic [2:0]        steps_p0;

    logic [ADDR_W:0]   sum_lr;
    logic [ADDR_W-1:0] mid;
    logic              do_init;
    logic              do_grab;
    logic              do_cmp;
    logic              eq;
    logic              lt;
    logic              gt;
    logic              f_c;
    logic              nf_c;

    // ---- combinational: midpoint, decode, compare ----
    always_comb begin
        // One extra bit so L+R never overflows before the halving.
        sum_lr = {1'b0, l_p0} + {1'b0, r_p0};
        mid    = sum_lr[ADDR_W:1];

        // load_A wins over every other strobe combination.
        do_init = bus.load_A;
        do_grab = bus.set_M & ~bus.set_L & ~bus.set_R & ~bus.load_A;
        do_cmp  = bus.set_M &  bus.set_L &  bus.set_R & ~bus.load_A;

        eq = (bus.mem_rdata == a_p0);
        lt = (bus.mem_rdata <  a_p0);
        gt = (bus.mem_rdata >  a_p0);

        // Not-found when the window has collapsed on the side the key
        // would have to move toward; this also guarantees L+1 / R-1 below
        // never wrap.
        f_c  = do_cmp & eq;
        nf_c = do_cmp & ~eq & ((lt & (m_p0 == r_p0)) | (gt & (m_p0 == l_p0)));
    end

    assign bus.mem_addr = mid;
    assign bus.F        = f_c;
    assign bus.NF       = nf_c;
    assign bus.Loc      = loc_p0;
    assign bus.found    = found_p0;
    assign bus.steps    = steps_p0;

    // ---- registered state ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_p0     <= '0;
            l_p0     <= '0;
            r_p0     <= R_INIT;
            m_p0     <= '0;
            found_p0 <= 1'b0;
            loc_p0   <= '0;
            steps_p0 <= 3'd0;
        end else if (do_init) begin
            a_p0     <= bus.A_in;
            l_p0     <= '0;
            r_p0     <= R_INIT;
            m_p0     <= '0;
            found_p0 <= 1'b0;
            loc_p0   <= '0;
            steps_p0 <= 3'd0;
        end else if (do_grab) begin
            m_p0 <= mid;
        end else if (do_cmp) begin
            steps_p0 <= sat_inc3(steps_p0);
            if (f_c) begin
                found_p0 <= 1'b1;
                loc_p0   <= m_p0;
            end else if (nf_c) begin
                found_p0 <= 1'b0;
            end else if (lt) begin
                l_p0 <= m_p0 + ADDR_W'(1);
            end else if (gt) begin
                r_p0 <= m_p0 - ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_binarysearch_datapath.sv
// ---------------------------------------------------------------------------
// tb_binarysearch_datapath
//
// Directed bench: a 32-word synchronous RAM holding mem[i] = 2*i is attached
// to the datapath, and a scripted controller drives init, then grab/compare
// pairs until F or NF is seen.
// ---------------------------------------------------------------------------
module tb_binarysearch_datapath;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    logic clock;
    logic reset;

    binarysearch_datapath_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    binarysearch_datapath #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [DATA_W-1:0] mem [32];

    int n_checks;
    int n_pass;

    int          mids [8];
    int          n_mids;
    logic        grab_flag_seen;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM with one cycle of read latency.
    always @(posedge clock) bus_if.mem_rdata <= mem[bus_if.mem_addr];

    task automatic clear_strobes();
        bus_if.load_A = 1'b0;
        bus_if.set_L  = 1'b0;
        bus_if.set_R  = 1'b0;
        bus_if.set_M  = 1'b0;
    endtask

    // Starts at a negedge; returns at a negedge with strobes cleared.
    task automatic do_init(input logic [DATA_W-1:0] key);
        @(negedge clock);
        clear_strobes();
        bus_if.A_in   = key;
        bus_if.load_A = 1'b1;
        @(negedge clock);
        clear_strobes();
    endtask

    // One grab cycle followed by one compare cycle; called at a negedge.
    task automatic grab_cmp(output logic f, output logic nf);
        bus_if.set_M = 1'b1;
        #1;
        if (n_mids < 8) mids[n_mids] = int'(bus_if.mem_addr);
        n_mids++;
        if (bus_if.F !== 1'b0 || bus_if.NF !== 1'b0) grab_flag_seen = 1'b1;
        @(negedge clock);
        bus_if.set_L = 1'b1;
        bus_if.set_R = 1'b1;
        #1;
        f  = bus_if.F;
        nf = bus_if.NF;
        @(negedge clock);
        clear_strobes();
    endtask

    task automatic run_search(input logic [DATA_W-1:0] key, output int ncmp,
                              output logic gf, output logic gnf);
        logic f, nf;
        n_mids = 0;
        grab_flag_seen = 1'b0;
        do_init(key);
        ncmp = 0;
        gf = 1'b0;
        gnf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            grab_cmp(f, nf);
            ncmp++;
            if (f === 1'b1 && nf === 1'b1) begin
                $display("FAIL f_nf_both key=%0d F=%b NF=%b required not both 1", key, f, nf);
            end
            gf = f;
            gnf = nf;
            if (f === 1'b1 || nf === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_strobes();
        bus_if.A_in = '0;
        #12;
        n_checks++;
        if (bus_if.mem_addr !== 5'd15 || bus_if.found !== 1'b0 || bus_if.Loc !== 5'd0 ||
            bus_if.steps !== 3'd0 || bus_if.F !== 1'b0 || bus_if.NF !== 1'b0)
            $display("FAIL reset_state got addr=%0d found=%b Loc=%0d steps=%0d F=%b NF=%b required 15 0 0 0 0 0",
                     bus_if.mem_addr, bus_if.found, bus_if.Loc, bus_if.steps, bus_if.F, bus_if.NF);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_found_20();
        int ncmp; logic gf, gnf;
        int exp_mids [5];
        logic mids_ok;
        exp_mids = '{15, 7, 11, 9, 10};
        run_search(8'd20, ncmp, gf, gnf);
        mids_ok = (n_mids == 5);
        for (int i = 0; i < 5; i++) if (mids[i] != exp_mids[i]) mids_ok = 1'b0;
        n_checks++;
        if (!mids_ok) $display("FAIL mids_20 got n=%0d %0d,%0d,%0d,%0d,%0d required 5 15,7,11,9,10",
                               n_mids, mids[0], mids[1], mids[2], mids[3], mids[4]);
        else n_pass++;
        n_checks++;
        if (gf !== 1'b1 || gnf !== 1'b0 || ncmp != 5)
            $display("FAIL term_20 got F=%b NF=%b cmps=%0d required 1 0 5", gf, gnf, ncmp);
        else n_pass++;
        n_checks++;
        if (bus_if.found !== 1'b1 || bus_if.Loc !== 5'd10 || bus_if.steps !== 3'd5)
            $display("FAIL result_20 got found=%b Loc=%0d steps=%0d required 1 10 5",
                     bus_if.found, bus_if.Loc, bus_if.steps);
        else n_pass++;
        n_checks++;
        if (grab_flag_seen !== 1'b0)
            $display("FAIL grab_flags got F/NF high in grab cycle required both 0");
        else n_pass++;
    endtask

    task automatic test_hold_idle();
        logic [ADDR_W-1:0] addr0;
        addr0 = bus_if.mem_addr;
        repeat (3) @(negedge clock);
        // Strobe combinations that decode to neither grab nor compare.
        bus_if.set_L = 1'b1;
        @(negedge clock);
        bus_if.set_M = 1'b1;
        #1;
        n_checks++;
        if (bus_if.F !== 1'b0 || bus_if.NF !== 1'b0)
            $display("FAIL illegal_combo_flags got F=%b NF=%b required 0 0", bus_if.F, bus_if.NF);
        else n_pass++;
        @(negedge clock);
        clear_strobes();
        n_checks++;
        if (bus_if.found !== 1'b1 || bus_if.Loc !== 5'd10 || bus_if.steps !== 3'd5 || bus_if.mem_addr !== addr0)
            $display("FAIL hold got found=%b Loc=%0d steps=%0d addr=%0d required 1 10 5 %0d",
                     bus_if.found, bus_if.Loc, bus_if.steps, bus_if.mem_addr, addr0);
        else n_pass++;
    endtask

    task automatic test_not_found_21();
        int ncmp; logic gf, gnf;
        run_search(8'd21, ncmp, gf, gnf);
        n_checks++;
        if (gf !== 1'b0 || gnf !== 1'b1 || ncmp != 5)
            $display("FAIL term_21 got F=%b NF=%b cmps=%0d required 0 1 5", gf, gnf, ncmp);
        else n_pass++;
        n_checks++;
        if (bus_if.found !== 1'b0 || bus_if.Loc !== 5'd0 || bus_if.steps !== 3'd5)
            $display("FAIL result_21 got found=%b Loc=%0d steps=%0d required 0 0 5",
                     bus_if.found, bus_if.Loc, bus_if.steps);
        else n_pass++;
    endtask

    task automatic test_bounds_0_62();
        int ncmp; logic gf, gnf;
        run_search(8'd0, ncmp, gf, gnf);
        n_checks++;
        if (gf !== 1'b1 || bus_if.found !== 1'b1 || bus_if.Loc !== 5'd0 || bus_if.steps !== 3'd5)
            $display("FAIL result_0 got F=%b found=%b Loc=%0d steps=%0d required 1 1 0 5",
                     gf, bus_if.found, bus_if.Loc, bus_if.steps);
        else n_pass++;
        run_search(8'd62, ncmp, gf, gnf);
        n_checks++;
        if (n_mids != 6 || mids[1] != 23 || mids[5] != 31)
            $display("FAIL mids_62 got n=%0d m1=%0d m5=%0d required 6 23 31", n_mids, mids[1], mids[5]);
        else n_pass++;
        n_checks++;
        if (gf !== 1'b1 || bus_if.found !== 1'b1 || bus_if.Loc !== 5'd31 || bus_if.steps !== 3'd6)
            $display("FAIL result_62 got F=%b found=%b Loc=%0d steps=%0d required 1 1 31 6",
                     gf, bus_if.found, bus_if.Loc, bus_if.steps);
        else n_pass++;
    endtask

    task automatic test_not_found_63_saturate();
        int ncmp; logic gf, gnf;
        logic f, nf;
        run_search(8'd63, ncmp, gf, gnf);
        n_checks++;
        if (gnf !== 1'b1 || gf !== 1'b0 || ncmp != 6 || mids[5] != 31)
            $display("FAIL term_63 got F=%b NF=%b cmps=%0d last_mid=%0d required 0 1 6 31",
                     gf, gnf, ncmp, mids[5]);
        else n_pass++;
        n_checks++;
        if (bus_if.found !== 1'b0 || bus_if.steps !== 3'd6 || bus_if.mem_addr !== 5'd31)
            $display("FAIL result_63 got found=%b steps=%0d addr=%0d required 0 6 31 (L must not wrap)",
                     bus_if.found, bus_if.steps, bus_if.mem_addr);
        else n_pass++;
        grab_cmp(f, nf);
        grab_cmp(f, nf);
        n_checks++;
        if (bus_if.steps !== 3'd7 || nf !== 1'b1 || bus_if.mem_addr !== 5'd31)
            $display("FAIL steps_saturate got steps=%0d NF=%b addr=%0d required 7 1 31",
                     bus_if.steps, nf, bus_if.mem_addr);
        else n_pass++;
    endtask

    task automatic test_reset_mid_search();
        int ncmp; logic gf, gnf;
        logic f, nf;
        n_mids = 0;
        do_init(8'd20);
        grab_cmp(f, nf);
        grab_cmp(f, nf);
        n_checks++;
        if (bus_if.steps !== 3'd2 || bus_if.mem_addr !== 5'd11)
            $display("FAIL pre_reset got steps=%0d addr=%0d required 2 11", bus_if.steps, bus_if.mem_addr);
        else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus_if.steps !== 3'd0 || bus_if.mem_addr !== 5'd15 || bus_if.found !== 1'b0 || bus_if.Loc !== 5'd0)
            $display("FAIL async_reset got steps=%0d addr=%0d found=%b Loc=%0d required 0 15 0 0",
                     bus_if.steps, bus_if.mem_addr, bus_if.found, bus_if.Loc);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        run_search(8'd20, ncmp, gf, gnf);
        n_checks++;
        if (bus_if.found !== 1'b1 || bus_if.Loc !== 5'd10 || bus_if.steps !== 3'd5)
            $display("FAIL after_reset_20 got found=%b Loc=%0d steps=%0d required 1 10 5",
                     bus_if.found, bus_if.Loc, bus_if.steps);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ncmp; logic gf, gnf;
        do_init(8'd40);
        n_checks++;
        if (bus_if.found !== 1'b0 || bus_if.steps !== 3'd0 || bus_if.Loc !== 5'd0)
            $display("FAIL init_clears got found=%b steps=%0d Loc=%0d required 0 0 0",
                     bus_if.found, bus_if.steps, bus_if.Loc);
        else n_pass++;
        run_search(8'd40, ncmp, gf, gnf);
        n_checks++;
        if (bus_if.found !== 1'b1 || bus_if.Loc !== 5'd20 || bus_if.steps !== 3'd5)
            $display("FAIL result_40 got found=%b Loc=%0d steps=%0d required 1 20 5",
                     bus_if.found, bus_if.Loc, bus_if.steps);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        n_mids = 0;
        grab_flag_seen = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = DATA_W'(2 * i);
        test_reset();
        test_found_20();
        test_hold_idle();
        test_not_found_21();
        test_bounds_0_62();
        test_not_found_63_saturate();
        test_reset_mid_search();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

endmodule
